// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared FSM state type and width helpers for the grid removal engine
package grid_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  function automatic int cnt_w(input int width, input int depth);
    return $clog2(width * depth + 1);
  endfunction

  function automatic int iter_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/grid_sweep.sv
// rtl/grid_sweep.sv - one combinational removal sweep over the whole grid
// GRID_TORUS_WRAP_EN: neighbours wrap around the grid edges instead of reading 0
module grid_sweep
  import grid_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int THRESH = 4,
  parameter int CNT_W  = cnt_w(WIDTH, DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] grid,
  output logic [DEPTH-1:0][WIDTH-1:0] swept,
  output logic [CNT_W-1:0]            removed,
  output logic                        any_removed
);

  localparam logic [3:0] THR = 4'(THRESH);

  // One-cell halo around the grid so every neighbour index is a constant
  logic [DEPTH+1:0][WIDTH+1:0] pad;
  logic [DEPTH-1:0][WIDTH-1:0] kill;

  for (genvar r = 0; r < DEPTH + 2; r++) begin : g_pad_row
    for (genvar c = 0; c < WIDTH + 2; c++) begin : g_pad_col
`ifdef GRID_TORUS_WRAP_EN
      localparam int SR = (r == 0) ? DEPTH - 1 : (r == DEPTH + 1) ? 0 : r - 1;
      localparam int SC = (c == 0) ? WIDTH - 1 : (c == WIDTH + 1) ? 0 : c - 1;
      assign pad[r][c] = grid[SR][SC];
`else
      if (r == 0 || r == DEPTH + 1 || c == 0 || c == WIDTH + 1) begin : g_edge
        assign pad[r][c] = 1'b0;
      end else begin : g_inner
        assign pad[r][c] = grid[r-1][c-1];
      end
`endif
    end
  end

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_cell
      logic [3:0] cnt;
      assign cnt = 4'(pad[r][c])   + 4'(pad[r][c+1])   + 4'(pad[r][c+2])
                 + 4'(pad[r+1][c])                     + 4'(pad[r+1][c+2])
                 + 4'(pad[r+2][c]) + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
      assign kill[r][c]  = grid[r][c] && (cnt < THR);
      assign swept[r][c] = grid[r][c] && !kill[r][c];
    end
  end

  assign removed     = CNT_W'($countones(kill));
  assign any_removed = |kill;

endmodule

// File: rtl/grid_removal_engine.sv
// rtl/grid_removal_engine.sv - load a grid, sweep away weakly connected cells, stream the result
// GRID_TORUS_WRAP_EN: selects wrap-around neighbourhoods in grid_sweep
module grid_removal_engine
  import grid_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int THRESH   = 4,
  parameter int MAX_ITER = 255,
  localparam int CNT_W   = cnt_w(WIDTH, DEPTH),
  localparam int ITER_W  = iter_w(MAX_ITER)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_row,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total_removed,
  output logic [ITER_W-1:0] iterations,
  output logic              saturated
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

  state_t                      state;
  logic [DEPTH-1:0][WIDTH-1:0] grid;
  logic [DEPTH-1:0][WIDTH-1:0] swept;
  logic [CNT_W-1:0]            sweep_removed;
  logic                        any_removed;
  logic [PTR_W-1:0]            load_ptr;
  logic [PTR_W-1:0]            rd_ptr;

  grid_sweep #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .THRESH(THRESH),
    .CNT_W (CNT_W)
  ) u_sweep (
    .grid       (grid),
    .swept      (swept),
    .removed    (sweep_removed),
    .any_removed(any_removed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grid          <= '0;
      load_ptr      <= '0;
      rd_ptr        <= '0;
      total_removed <= '0;
      iterations    <= '0;
      saturated     <= 1'b0;
      done          <= 1'b0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            total_removed <= '0;
            iterations    <= '0;
            saturated     <= 1'b0;
            load_ptr      <= '0;
            in_ready      <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            grid[load_ptr] <= in_row;
            if (load_ptr == PTR_LAST) begin
              in_ready <= 1'b0;
              state    <= RUN;
            end else begin
              load_ptr <= load_ptr + PTR_W'(1);
            end
          end
        end
        RUN: begin
          grid          <= swept;
          total_removed <= total_removed + sweep_removed;
          if (any_removed) iterations <= iterations + ITER_W'(1);
          // Stop on a quiet sweep, or on the sweep that uses up the iteration budget
          if (!any_removed || iterations == ITER_LAST) begin
            saturated <= any_removed;
            done      <= 1'b1;
            out_valid <= 1'b1;
            rd_ptr    <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == PTR_LAST) begin
              out_valid <= 1'b0;
              rd_ptr    <= '0;
              state     <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + PTR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_row = grid[rd_ptr];
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_grid_removal_engine.sv
// tb/tb_grid_removal_engine.sv - directed table-driven bench for grid_removal_engine
module tb_grid_removal_engine;

  typedef logic [15:0][15:0] grid_t;

  typedef struct {
    grid_t in_grid;
    grid_t exp_grid;
    bit    use_sat;
    bit    bp;
    int    exp_total;
    int    exp_iters;
    bit    exp_sat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_m, start_s, in_valid, out_ready;
  logic [15:0] in_row;

  logic        in_ready_m, out_valid_m, busy_m, done_m, sat_m;
  logic [15:0] out_row_m;
  logic [8:0]  total_m;
  logic [7:0]  iters_m;

  logic        in_ready_s, out_valid_s, busy_s, done_s, sat_s;
  logic [15:0] out_row_s;
  logic [8:0]  total_s;
  logic [0:0]  iters_s;

  grid_removal_engine #(.WIDTH(16), .DEPTH(16), .THRESH(4), .MAX_ITER(255)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_row(in_row), .out_valid(out_valid_m), .out_ready(out_ready), .out_row(out_row_m),
    .busy(busy_m), .done(done_m), .total_removed(total_m), .iterations(iters_m),
    .saturated(sat_m)
  );

  grid_removal_engine #(.WIDTH(16), .DEPTH(16), .THRESH(4), .MAX_ITER(1)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_row(in_row), .out_valid(out_valid_s), .out_ready(out_ready), .out_row(out_row_s),
    .busy(busy_s), .done(done_s), .total_removed(total_s), .iterations(iters_s),
    .saturated(sat_s)
  );

  logic        sel;
  logic        v_in_ready, v_out_valid, v_busy, v_done, v_sat;
  logic [15:0] v_out_row;
  logic [8:0]  v_total;
  logic [7:0]  v_iters;

  always_comb begin
    v_in_ready  = sel ? in_ready_s  : in_ready_m;
    v_out_valid = sel ? out_valid_s : out_valid_m;
    v_busy      = sel ? busy_s      : busy_m;
    v_done      = sel ? done_s      : done_m;
    v_sat       = sel ? sat_s       : sat_m;
    v_out_row   = sel ? out_row_s   : out_row_m;
    v_total     = sel ? total_s     : total_m;
    v_iters     = sel ? 8'(iters_s) : iters_m;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic grid_t block(input int r0, input int c0, input int h, input int w);
    grid_t g = '0;
    for (int r = r0; r < r0 + h; r++)
      for (int c = c0; c < c0 + w; c++) g[r][c] = 1'b1;
    return g;
  endfunction

  function automatic vec_t mk(input grid_t gi, input grid_t ge, input bit s, input bit bp,
                              input int t, input int it, input bit sat);
    vec_t v;
    v.in_grid = gi; v.exp_grid = ge; v.use_sat = s; v.bp = bp;
    v.exp_total = t; v.exp_iters = it; v.exp_sat = sat;
    return v;
  endfunction

  task automatic start_and_load(input bit use_sat, input grid_t g, input int id);
    int n;
    sel = use_sat;
    @(negedge clk);
    if (use_sat) start_s = 1'b1; else start_m = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_m = 1'b0;
    check($sformatf("c%0d_busy_after_start", id), 32'(v_busy), 1);
    for (int r = 0; r < 16; r++) begin
      in_valid = 1'b1;
      in_row   = g[r];
      n = 0;
      while (!v_in_ready && n < 50) begin @(negedge clk); n++; end
      check($sformatf("c%0d_in_ready_row%0d", id, r), 32'(v_in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input int id);
    int k, r, cyc;
    start_and_load(v.use_sat, v.in_grid, id);
    k = 0;
    while (!v_done && k < 600) begin @(negedge clk); k++; end
    check($sformatf("c%0d_sweeps", id), 32'(k), 32'(v.exp_sat ? v.exp_iters : v.exp_iters + 1));
    check($sformatf("c%0d_total", id), 32'(v_total), 32'(v.exp_total));
    check($sformatf("c%0d_iters", id), 32'(v_iters), 32'(v.exp_iters));
    check($sformatf("c%0d_saturated", id), 32'(v_sat), 32'(v.exp_sat));
    r = 0;
    cyc = 0;
    while (r < 16 && cyc < 400) begin
      out_ready = v.bp ? (cyc % 2 == 1) : 1'b1;
      if (cyc == 1) check($sformatf("c%0d_done_one_cycle", id), 32'(v_done), 0);
      check($sformatf("c%0d_out_valid_row%0d", id, r), 32'(v_out_valid), 1);
      check($sformatf("c%0d_out_row%0d", id, r), 32'(v_out_row), 32'(v.exp_grid[r]));
      if (out_ready) r++;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check($sformatf("c%0d_rows_drained", id), 32'(r), 16);
    check($sformatf("c%0d_idle_after_drain", id), 32'(v_busy), 0);
    check($sformatf("c%0d_out_valid_low", id), 32'(v_out_valid), 0);
    check($sformatf("c%0d_total_held", id), 32'(v_total), 32'(v.exp_total));
  endtask

  vec_t  vecs[7];
  grid_t g, e;

  initial begin
    rst = 1'b1; start_m = 1'b0; start_s = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_row = '0; sel = 1'b0;

    vecs[0] = mk(block(0, 0, 3, 3), '0, 1'b0, 1'b0, 9, 3, 1'b0);
    vecs[1] = mk('0, '0, 1'b0, 1'b0, 0, 0, 1'b0);
    e = '0; e[5] = 16'h0040; e[6] = 16'h00E0; e[7] = 16'h0040;
    vecs[2] = mk(block(5, 5, 3, 3), e, 1'b1, 1'b0, 4, 1, 1'b1);
    g = '1;
`ifdef GRID_TORUS_WRAP_EN
    vecs[3] = mk(g, g, 1'b0, 1'b0, 0, 0, 1'b0);
`else
    e = g; e[0] = 16'h7FFE; e[15] = 16'h7FFE;
    vecs[3] = mk(g, e, 1'b0, 1'b0, 4, 1, 1'b0);
`endif
    vecs[4] = mk(block(8, 0, 1, 16), '0, 1'b0, 1'b0, 16, 1, 1'b0);
    e = '0; e[4] = 16'h0060; e[5] = 16'h00F0; e[6] = 16'h00F0; e[7] = 16'h0060;
    vecs[5] = mk(block(4, 4, 4, 4), e, 1'b0, 1'b0, 4, 1, 1'b0);
    g = '1;
    for (int r = 2; r < 14; r++) g[r][r] = 1'b0;
`ifdef GRID_TORUS_WRAP_EN
    vecs[6] = mk(g, g, 1'b0, 1'b1, 0, 0, 1'b0);
`else
    e = g; e[0] = 16'h7FFE; e[15] = 16'h7FFE;
    vecs[6] = mk(g, e, 1'b0, 1'b1, 4, 1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy_m | busy_s), 0);
    check("reset_in_ready", 32'(in_ready_m | in_ready_s), 0);
    check("reset_out_valid", 32'(out_valid_m | out_valid_s), 0);
    check("reset_done", 32'(done_m | done_s), 0);
    check("reset_total", 32'(total_m), 0);
    check("reset_iters", 32'(iters_m), 0);
    check("reset_out_row", 32'(out_row_m), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_case(vecs[i], i);

    // Reset in the middle of a run, after the first sweep has already counted removals
    start_and_load(1'b0, block(0, 0, 3, 3), 10);
    @(negedge clk);
    check("midrun_busy", 32'(busy_m), 1);
    check("midrun_total", 32'(total_m), 4);
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy_m), 0);
    check("rst_done", 32'(done_m), 0);
    check("rst_out_valid", 32'(out_valid_m), 0);
    check("rst_in_ready", 32'(in_ready_m), 0);
    check("rst_total", 32'(total_m), 0);
    check("rst_iters", 32'(iters_m), 0);
    check("rst_saturated", 32'(sat_m), 0);
    check("rst_out_row", 32'(out_row_m), 0);
    @(negedge clk);
    rst = 1'b0;
    run_case(vecs[0], 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grid_removal_engine.md
GRID_REMOVAL_ENGINE -- requirements
Module: grid_removal_engine

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 16: grid columns.
- DEPTH, default 16: grid rows.
- THRESH, default 4: a set cell is removed when its set-neighbour count is below THRESH; legal range 1..8.
- MAX_ITER, default 255: sweep limit per run.

REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run.
- in_valid  in  1  load-row valid.
- in_ready  out  1  load-row ready.
- in_row  in  WIDTH  load row; bit j is column j; 1 = paper.
- out_valid  out  1  readback-row valid.
- out_ready  in  1  readback-row ready.
- out_row  out  WIDTH  final grid row.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the run completes.
- total_removed  out  CNT_W  total cells removed in the run.
- iterations  out  ITER_W  number of sweeps that removed at least one cell.
- saturated  out  1  MAX_ITER was reached while cells were still being removed.

REQ-003 Widths SHALL be CNT_W = $clog2(WIDTH*DEPTH+1) and ITER_W = $clog2(MAX_ITER+1).

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, RUN, DRAIN.
REQ-005 In IDLE, start=1 SHALL:
- clear total_removed, iterations, saturated and the load pointer;
- move the FSM to LOAD on the next edge.
start is ignored in every other state.
REQ-006 In LOAD, in_ready SHALL be 1. Each in_valid&&in_ready beat SHALL:
- write in_row to grid row load_ptr, row 0 first;
- increment load_ptr.
After the DEPTH-th beat the FSM SHALL move to RUN.
REQ-007 In RUN, every cycle SHALL perform one full sweep over the registered grid:
- all cells are evaluated simultaneously against the pre-sweep grid;
- out-of-grid neighbours count as 0;
- a cell is removed when it is set and its neighbour count is below THRESH.
REQ-008 Each RUN cycle SHALL update registers as follows:
- grid <= swept grid;
- total_removed += removed count;
- iterations += 1 when the removed count is non-zero.
REQ-009 RUN SHALL exit to DRAIN after:
- a sweep that removed nothing; or
- the sweep that brings iterations to MAX_ITER. saturated SHALL be set if that sweep removed cells.
REQ-010 done SHALL pulse for exactly one cycle, the first cycle in DRAIN.
REQ-011 In DRAIN, the readback stream SHALL behave as follows:
- out_valid = 1 and out_row = grid[rd_ptr];
- on each out_ready beat, rd_ptr increments;
- out_row stays stable while out_valid && !out_ready;
- after the DEPTH-th beat the FSM SHALL return to IDLE.
REQ-012 total_removed, iterations and saturated SHALL hold their values in IDLE until the next accepted start.
REQ-013 Neighbour counts SHALL be 4-bit. The per-sweep removed count and total_removed SHALL be CNT_W wide and cannot overflow.
REQ-014 With THRESH=1, only isolated cells SHALL be removed. With THRESH above 8, the behaviour is undefined.

Reset
REQ-015 rst SHALL asynchronously force the following, from any state including mid-LOAD, RUN or DRAIN:
- FSM to IDLE; grid to all-zero; all pointers to 0;
- total_removed, iterations, saturated, done, out_valid and in_ready to 0.

Configuration
REQ-016 When GRID_TORUS_WRAP_EN is defined, neighbour indices SHALL wrap modulo WIDTH and DEPTH, so every cell has 8 neighbours.
REQ-017 When the macro is undefined, out-of-grid neighbours SHALL count as 0.

Structure
REQ-018 Package grid_pkg SHALL hold:
- the state enum;
- functions cnt_w(WIDTH,DEPTH) and iter_w(MAX_ITER).
REQ-019 The combinational single-sweep logic SHALL be sub-module grid_sweep:
- inputs: grid, THRESH;
- outputs: swept grid, removed count, any_removed.
grid_removal_engine holds the FSM, the grid registers and the counters.

Verification
REQ-020 Scenario 1, 3x3 all-ones, THRESH=4:
- sweeps remove 4, 4, 1;
- expect total_removed=9, iterations=3, saturated=0;
- all readback rows are 0.
REQ-021 Scenario 2, 16x16 all-zero:
- RUN lasts 1 cycle;
- done pulses; total_removed=0, iterations=0.
REQ-022 Scenario 3, 3x3 all-ones with MAX_ITER=1:
- total_removed=4, iterations=1, saturated=1;
- readback shows the plus-shape rows 010/111/010.
REQ-023 Scenario 4, 16x16 all-ones:
- with GRID_TORUS_WRAP_EN: total_removed=0, iterations=0;
- without the macro: the first sweep removes exactly the 4 corners.
REQ-024 Scenario 5, readback back-pressure:
- toggle out_ready every other cycle during DRAIN;
- each row appears exactly once, in order, stable while stalled;
- IDLE is reached after 16 beats.
REQ-025 Scenario 6, reset mid-run:
- assert rst during RUN;
- all outputs read 0 in the same cycle;
- a fresh start then completes with correct results.
